// File: rtl/up_counter_mod_pkg.sv
// Shared definitions for the mod-N up counter and the reworked down counter.
// Holds the FSM state encoding and the terminal-count helper.
package up_counter_mod_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } cnt_state_t;

  // Terminal count for a counter whose range is 0..modulus-1.
  function automatic int max_cnt(input int modulus);
    return modulus - 1;
  endfunction

endpackage

// File: rtl/up_counter_mod.sv
// Mod-N up counter with enable, synchronous clamped load, free-run/one-shot modes.
// Latency: 1 clk from en/load to out; no backpressure, tc is the cascade carry.
module up_counter_mod
  import up_counter_mod_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             one_shot,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap,
  output logic             done,
  output logic             err
);

  localparam int               MAX_CNT = max_cnt(MODULUS);
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_CNT);

  cnt_state_t       r_state;
  logic [WIDTH-1:0] r_cnt;
  logic             r_wrap;
  logic             r_done;
  logic             r_err;

  cnt_state_t       w_state_nxt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_wrap_nxt;
  logic             w_done_nxt;
  logic             w_err_nxt;
  logic             w_at_max;
  logic             w_load_over;

  assign w_at_max    = (r_cnt == MAX_W);
  // Widened compare so MODULUS == 2**WIDTH never needs an out-of-range constant.
  assign w_load_over = ({1'b0, load_val} > {1'b0, MAX_W});

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wrap_nxt  = 1'b0;
    w_done_nxt  = r_done;
    w_err_nxt   = r_err;

    if (load) begin
      w_cnt_nxt   = w_load_over ? MAX_W : load_val;
      w_err_nxt   = r_err | w_load_over;
      w_done_nxt  = 1'b0;
      w_state_nxt = COUNT;
    end else begin
      case (r_state)
        IDLE, COUNT: begin
          if (en) begin
            w_state_nxt = COUNT;
            if (!w_at_max) begin
              w_cnt_nxt = r_cnt + WIDTH'(1);
            end else if (one_shot) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = DONE;
            end else begin
              w_cnt_nxt  = '0;
              w_wrap_nxt = 1'b1;
            end
          end
        end
        DONE: begin
          w_done_nxt = 1'b1;
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wrap  <= w_wrap_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign out  = r_cnt;
  // Suppressed in DONE so a frozen one-shot stage cannot keep carrying.
  assign tc   = w_at_max && en && (r_state != DONE);
  assign wrap = r_wrap;
  assign done = r_done;
  assign err  = r_err;

endmodule

// File: tb/tb_up_counter_mod.sv
// Directed bench: MODULUS=10 instance for the main scenarios, MODULUS=16 for the
// power-of-two regression; both share the same stimulus.
module tb_up_counter_mod;

  logic       clk;
  logic       reset;
  logic       en;
  logic       load;
  logic [3:0] load_val;
  logic       one_shot;

  logic [3:0] out10, out16;
  logic       tc10, wrap10, done10, err10;
  logic       tc16, wrap16, done16, err16;

  int n_cmp;
  int n_bad;

  up_counter_mod #(.WIDTH(4), .MODULUS(10)) dut10 (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .one_shot(one_shot), .out(out10), .tc(tc10), .wrap(wrap10),
    .done(done10), .err(err10)
  );

  up_counter_mod #(.WIDTH(4), .MODULUS(16)) dut16 (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .one_shot(one_shot), .out(out16), .tc(tc16), .wrap(wrap16),
    .done(done16), .err(err16)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b0; load = 1'b0; load_val = 4'd0; one_shot = 1'b0;
    tick(); tick();
    n_cmp++; if (out10 !== 4'd0) begin n_bad++; $display("FAIL reset_out: got %0d want 0", out10); end
    n_cmp++; if (wrap10 !== 1'b0) begin n_bad++; $display("FAIL reset_wrap: got %b want 0", wrap10); end
    n_cmp++; if (done10 !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done10); end
    n_cmp++; if (err10 !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err10); end
    reset = 1'b1;
    tick(); tick();
    n_cmp++; if (out10 !== 4'd0) begin n_bad++; $display("FAIL idle_hold_out: got %0d want 0", out10); end
    n_cmp++; if (tc10 !== 1'b0) begin n_bad++; $display("FAIL idle_tc: got %b want 0", tc10); end
  endtask

  task automatic test_free_run();
    logic [3:0] exp;
    exp = 4'd0;
    en = 1'b1; one_shot = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      #1;
      n_cmp++;
      if (tc10 !== (exp == 4'd9)) begin
        n_bad++; $display("FAIL free_tc step %0d: got %b want %b", i, tc10, exp == 4'd9);
      end
      tick();
      exp = (exp == 4'd9) ? 4'd0 : exp + 4'd1;
      n_cmp++;
      if (out10 !== exp) begin
        n_bad++; $display("FAIL free_out step %0d: got %0d want %0d", i, out10, exp);
      end
      n_cmp++;
      if (wrap10 !== (i == 10)) begin
        n_bad++; $display("FAIL free_wrap step %0d: got %b want %b", i, wrap10, i == 10);
      end
    end
  endtask

  task automatic test_enable_hold();
    en = 1'b1;
    tick(); tick();
    n_cmp++; if (out10 !== 4'd4) begin n_bad++; $display("FAIL hold_pre: got %0d want 4", out10); end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (out10 !== 4'd4) begin n_bad++; $display("FAIL hold_cycle %0d: got %0d want 4", i, out10); end
    end
    en = 1'b1;
    tick();
    n_cmp++; if (out10 !== 4'd5) begin n_bad++; $display("FAIL hold_resume: got %0d want 5", out10); end
  endtask

  task automatic test_load();
    en = 1'b0; load = 1'b1; load_val = 4'd2;
    tick();
    n_cmp++; if (out10 !== 4'd2) begin n_bad++; $display("FAIL load_2: got %0d want 2", out10); end
    en = 1'b1; load = 1'b1; load_val = 4'd5;
    tick();
    n_cmp++; if (out10 !== 4'd5) begin n_bad++; $display("FAIL load_beats_en: got %0d want 5", out10); end
    load = 1'b0;
    tick();
    n_cmp++; if (out10 !== 4'd6) begin n_bad++; $display("FAIL load_then_inc: got %0d want 6", out10); end
    n_cmp++; if (err10 !== 1'b0) begin n_bad++; $display("FAIL load_no_err: got %b want 0", err10); end
  endtask

  task automatic test_one_shot();
    en = 1'b1; one_shot = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (out10 !== 4'd9) begin n_bad++; $display("FAIL os_reach9: got %0d want 9", out10); end
    n_cmp++; if (done10 !== 1'b0) begin n_bad++; $display("FAIL os_done_early: got %b want 0", done10); end
    n_cmp++; if (tc10 !== 1'b1) begin n_bad++; $display("FAIL os_tc_at9: got %b want 1", tc10); end
    tick();
    n_cmp++; if (out10 !== 4'd9) begin n_bad++; $display("FAIL os_freeze: got %0d want 9", out10); end
    n_cmp++; if (done10 !== 1'b1) begin n_bad++; $display("FAIL os_done: got %b want 1", done10); end
    n_cmp++; if (wrap10 !== 1'b0) begin n_bad++; $display("FAIL os_no_wrap: got %b want 0", wrap10); end
    n_cmp++; if (tc10 !== 1'b0) begin n_bad++; $display("FAIL os_tc_in_done: got %b want 0", tc10); end
    tick(); tick();
    n_cmp++; if (out10 !== 4'd9 || done10 !== 1'b1) begin
      n_bad++; $display("FAIL os_stay_done: got out=%0d done=%b want out=9 done=1", out10, done10);
    end
    load = 1'b1; load_val = 4'd0;
    tick();
    load = 1'b0; en = 1'b0;
    n_cmp++; if (out10 !== 4'd0) begin n_bad++; $display("FAIL os_reload: got %0d want 0", out10); end
    n_cmp++; if (done10 !== 1'b0) begin n_bad++; $display("FAIL os_done_clear: got %b want 0", done10); end
    one_shot = 1'b0;
  endtask

  task automatic test_err_and_reset();
    load = 1'b1; load_val = 4'd12; en = 1'b0;
    tick();
    load = 1'b0;
    n_cmp++; if (out10 !== 4'd9) begin n_bad++; $display("FAIL err_clamp: got %0d want 9", out10); end
    n_cmp++; if (err10 !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b want 1", err10); end
    en = 1'b1;
    tick();
    n_cmp++; if (out10 !== 4'd0 || wrap10 !== 1'b1) begin
      n_bad++; $display("FAIL err_wrap: got out=%0d wrap=%b want out=0 wrap=1", out10, wrap10);
    end
    n_cmp++; if (err10 !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", err10); end
    for (int i = 0; i < 7; i++) tick();
    n_cmp++; if (out10 !== 4'd7) begin n_bad++; $display("FAIL err_count7: got %0d want 7", out10); end
    reset = 1'b0; load = 1'b1; load_val = 4'd3;
    tick();
    n_cmp++; if (out10 !== 4'd0) begin n_bad++; $display("FAIL midreset_out: got %0d want 0", out10); end
    n_cmp++; if (err10 !== 1'b0) begin n_bad++; $display("FAIL midreset_err: got %b want 0", err10); end
    reset = 1'b1; load = 1'b0; en = 1'b0;
    tick();
  endtask

  task automatic test_mod16();
    logic [3:0] exp;
    reset = 1'b0; en = 1'b0; load = 1'b0; one_shot = 1'b0;
    tick();
    reset = 1'b1; en = 1'b1;
    exp = 4'd0;
    for (int i = 1; i <= 16; i++) begin
      #1;
      n_cmp++;
      if (tc16 !== (exp == 4'd15)) begin
        n_bad++; $display("FAIL m16_tc step %0d: got %b want %b", i, tc16, exp == 4'd15);
      end
      tick();
      exp = exp + 4'd1;
      n_cmp++;
      if (out16 !== exp || wrap16 !== (i == 16)) begin
        n_bad++; $display("FAIL m16_step %0d: got out=%0d wrap=%b want out=%0d wrap=%b",
                          i, out16, wrap16, exp, i == 16);
      end
    end
    en = 1'b0; load = 1'b1; load_val = 4'd15;
    tick();
    load = 1'b0;
    n_cmp++; if (out16 !== 4'd15 || err16 !== 1'b0) begin
      n_bad++; $display("FAIL m16_load15: got out=%0d err=%b want out=15 err=0", out16, err16);
    end
    n_cmp++; if (done16 !== 1'b0) begin n_bad++; $display("FAIL m16_done: got %b want 0", done16); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_free_run();
    test_enable_hold();
    test_load();
    test_one_shot();
    test_err_and_reset();
    test_mod16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
